// File: rtl/uart_tx_fifo_if.sv
// Application/transmitter-side signal bundle for uart_tx_fifo.
// The slave modport is the FIFO itself; master is whoever drives writes and done ticks.
interface uart_tx_fifo_if #(
    parameter int NB_DATA = 8,
    parameter int NB_ADDR = 4
);
    logic               i_wr;
    logic [NB_DATA-1:0] i_wr_data;
    logic               o_full;
    logic               o_empty;
    logic [NB_ADDR:0]   o_count;
    logic               o_overflow;
    logic               i_tx_done_tick;
    logic               o_tx_start;
    logic [NB_DATA-1:0] o_tx_data;

    modport slave (
        input  i_wr, i_wr_data, i_tx_done_tick,
        output o_full, o_empty, o_count, o_overflow, o_tx_start, o_tx_data
    );

    modport master (
        output i_wr, i_wr_data, i_tx_done_tick,
        input  o_full, o_empty, o_count, o_overflow, o_tx_start, o_tx_data
    );
endinterface

// File: rtl/uart_tx_fifo.sv
// Circular transmit FIFO feeding a UART transmitter one frame at a time:
// pops a word with a one-cycle start pulse, then waits for the done tick.
//
// state   | meaning
// IDLE    | no frame outstanding; pop as soon as the FIFO is non-empty
// WAIT    | frame handed to transmitter; hold until done tick
module uart_tx_fifo #(
    parameter int NB_DATA = 8,
    parameter int NB_ADDR = 4
) (
    input  logic           i_clock,
    input  logic           i_reset,
    uart_tx_fifo_if.slave  bus
);
    localparam int DEPTH = 1 << NB_ADDR;

    typedef enum logic {
        ST_IDLE,
        ST_WAIT
    } state_t;

    state_t               state_q, state_d;
    logic [NB_ADDR-1:0]   wr_ptr_q, wr_ptr_d;
    logic [NB_ADDR-1:0]   rd_ptr_q, rd_ptr_d;
    logic [NB_ADDR:0]     count_q, count_d;
    logic                 tx_start_q, tx_start_d;
    logic [NB_DATA-1:0]   tx_data_q, tx_data_d;
    logic                 overflow_q, overflow_d;
    logic [NB_DATA-1:0]   mem_q [DEPTH];

    logic full, empty, wr_accept, pop;

    assign full  = (count_q == (NB_ADDR+1)'(DEPTH));
    assign empty = (count_q == '0);

    // Full is judged on the pre-edge count, so a pop at the same edge does not rescue a write.
    assign wr_accept = bus.i_wr && !full;

    always_comb begin
        state_d    = state_q;
        pop        = 1'b0;
        tx_start_d = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (!empty) begin
                    pop        = 1'b1;
                    tx_start_d = 1'b1;
                    state_d    = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (bus.i_tx_done_tick) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        count_d    = count_q;
        tx_data_d  = tx_data_q;
        overflow_d = bus.i_wr && full;
        if (wr_accept) begin
            wr_ptr_d = wr_ptr_q + NB_ADDR'(1);
        end
        if (pop) begin
            rd_ptr_d  = rd_ptr_q + NB_ADDR'(1);
            tx_data_d = mem_q[rd_ptr_q];
        end
        if (wr_accept && !pop) begin
            count_d = count_q + (NB_ADDR+1)'(1);
        end else if (pop && !wr_accept) begin
            count_d = count_q - (NB_ADDR+1)'(1);
        end
    end

    always_ff @(posedge i_clock or negedge i_reset) begin
        if (!i_reset) begin
            state_q    <= ST_IDLE;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            tx_start_q <= 1'b0;
            tx_data_q  <= '0;
            overflow_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            tx_start_q <= tx_start_d;
            tx_data_q  <= tx_data_d;
            overflow_q <= overflow_d;
        end
    end

    // Storage is not reset; occupancy and pointers alone define validity.
    always_ff @(posedge i_clock) begin
        if (wr_accept) begin
            mem_q[wr_ptr_q] <= bus.i_wr_data;
        end
    end

    assign bus.o_full     = full;
    assign bus.o_empty    = empty;
    assign bus.o_count    = count_q;
    assign bus.o_overflow = overflow_q;
    assign bus.o_tx_start = tx_start_q;
    assign bus.o_tx_data  = tx_data_q;
endmodule

// File: tb/tb_uart_tx_fifo.sv
// Directed bench for uart_tx_fifo: inputs change on falling edges, outputs are
// sampled on falling edges, so each observation reflects the preceding rising edge.
module tb_uart_tx_fifo;
    logic i_clock = 1'b0;
    logic i_reset = 1'b0;
    int   checks  = 0;
    int   errors  = 0;

    uart_tx_fifo_if #(.NB_DATA(8), .NB_ADDR(4)) bus ();

    uart_tx_fifo #(.NB_DATA(8), .NB_ADDR(4)) dut (
        .i_clock (i_clock),
        .i_reset (i_reset),
        .bus     (bus)
    );

    always #5 i_clock = ~i_clock;

    task automatic do_reset();
        @(negedge i_clock);
        i_reset            = 1'b0;
        bus.i_wr           = 1'b0;
        bus.i_wr_data      = 8'h00;
        bus.i_tx_done_tick = 1'b0;
        @(negedge i_clock);
        i_reset = 1'b1;
    endtask

    task automatic test_reset();
        i_reset = 1'b0;
        for (int i = 0; i < 6; i++) begin
            @(negedge i_clock);
            bus.i_wr           = 1'($urandom_range(0, 1));
            bus.i_wr_data      = 8'($urandom_range(0, 255));
            bus.i_tx_done_tick = 1'($urandom_range(0, 1));
        end
        @(negedge i_clock);
        checks++; if (bus.o_empty !== 1'b1)   begin errors++; $display("FAIL reset_empty got %0b exp 1", bus.o_empty); end
        checks++; if (bus.o_full !== 1'b0)    begin errors++; $display("FAIL reset_full got %0b exp 0", bus.o_full); end
        checks++; if (bus.o_count !== 5'd0)   begin errors++; $display("FAIL reset_count got %0d exp 0", bus.o_count); end
        checks++; if (bus.o_tx_start !== 1'b0) begin errors++; $display("FAIL reset_start got %0b exp 0", bus.o_tx_start); end
        checks++; if (bus.o_tx_data !== 8'h00) begin errors++; $display("FAIL reset_data got %0h exp 00", bus.o_tx_data); end
        checks++; if (bus.o_overflow !== 1'b0) begin errors++; $display("FAIL reset_overflow got %0b exp 0", bus.o_overflow); end
        bus.i_wr           = 1'b0;
        bus.i_tx_done_tick = 1'b0;
        i_reset            = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge i_clock);
            checks++; if (bus.o_tx_start !== 1'b0) begin errors++; $display("FAIL idle_empty_start cyc %0d got %0b exp 0", i, bus.o_tx_start); end
        end
    endtask

    task automatic test_single_byte();
        do_reset();
        bus.i_wr      = 1'b1;
        bus.i_wr_data = 8'hA5;
        @(negedge i_clock);
        bus.i_wr = 1'b0;
        checks++; if (bus.o_empty !== 1'b0)    begin errors++; $display("FAIL single_empty_after_e0 got %0b exp 0", bus.o_empty); end
        checks++; if (bus.o_count !== 5'd1)    begin errors++; $display("FAIL single_count_after_e0 got %0d exp 1", bus.o_count); end
        checks++; if (bus.o_tx_start !== 1'b0) begin errors++; $display("FAIL single_start_after_e0 got %0b exp 0", bus.o_tx_start); end
        @(negedge i_clock);
        checks++; if (bus.o_tx_start !== 1'b1) begin errors++; $display("FAIL single_start_after_e1 got %0b exp 1", bus.o_tx_start); end
        checks++; if (bus.o_tx_data !== 8'hA5) begin errors++; $display("FAIL single_data got %0h exp a5", bus.o_tx_data); end
        checks++; if (bus.o_count !== 5'd0)    begin errors++; $display("FAIL single_count_after_pop got %0d exp 0", bus.o_count); end
        for (int i = 0; i < 5; i++) begin
            @(negedge i_clock);
            checks++; if (bus.o_tx_start !== 1'b0) begin errors++; $display("FAIL single_no_restart cyc %0d got %0b exp 0", i, bus.o_tx_start); end
        end
        checks++; if (bus.o_tx_data !== 8'hA5) begin errors++; $display("FAIL single_data_stable got %0h exp a5", bus.o_tx_data); end
        bus.i_tx_done_tick = 1'b1;
        @(negedge i_clock);
        bus.i_tx_done_tick = 1'b0;
        @(negedge i_clock);
        checks++; if (bus.o_count !== 5'd0)    begin errors++; $display("FAIL single_count_after_tick got %0d exp 0", bus.o_count); end
        checks++; if (bus.o_tx_start !== 1'b0) begin errors++; $display("FAIL single_start_after_tick got %0b exp 0", bus.o_tx_start); end
    endtask

    task automatic test_fill_overflow();
        do_reset();
        for (int k = 0; k <= 16; k++) begin
            bus.i_wr      = 1'b1;
            bus.i_wr_data = 8'(k);
            @(negedge i_clock);
            if (k == 15) begin
                checks++; if (bus.o_count !== 5'd15) begin errors++; $display("FAIL fill_count15 got %0d exp 15", bus.o_count); end
                checks++; if (bus.o_full !== 1'b0)   begin errors++; $display("FAIL fill_full_at15 got %0b exp 0", bus.o_full); end
            end
        end
        checks++; if (bus.o_count !== 5'd16)    begin errors++; $display("FAIL fill_count16 got %0d exp 16", bus.o_count); end
        checks++; if (bus.o_full !== 1'b1)      begin errors++; $display("FAIL fill_full got %0b exp 1", bus.o_full); end
        checks++; if (bus.o_overflow !== 1'b0)  begin errors++; $display("FAIL fill_no_overflow got %0b exp 0", bus.o_overflow); end
        checks++; if (bus.o_tx_data !== 8'h00)  begin errors++; $display("FAIL fill_first_popped got %0h exp 00", bus.o_tx_data); end
        bus.i_wr_data = 8'h11;
        @(negedge i_clock);
        checks++; if (bus.o_overflow !== 1'b1)  begin errors++; $display("FAIL ovf_pulse1 got %0b exp 1", bus.o_overflow); end
        checks++; if (bus.o_count !== 5'd16)    begin errors++; $display("FAIL ovf_count got %0d exp 16", bus.o_count); end
        bus.i_wr_data = 8'h12;
        @(negedge i_clock);
        checks++; if (bus.o_overflow !== 1'b1)  begin errors++; $display("FAIL ovf_pulse2 got %0b exp 1", bus.o_overflow); end
        bus.i_wr = 1'b0;
        @(negedge i_clock);
        checks++; if (bus.o_overflow !== 1'b0)  begin errors++; $display("FAIL ovf_clear got %0b exp 0", bus.o_overflow); end
        checks++; if (bus.o_count !== 5'd16)    begin errors++; $display("FAIL ovf_count_hold got %0d exp 16", bus.o_count); end
        for (int j = 1; j <= 16; j++) begin
            bus.i_tx_done_tick = 1'b1;
            @(negedge i_clock);
            bus.i_tx_done_tick = 1'b0;
            @(negedge i_clock);
            checks++; if (bus.o_tx_start !== 1'b1)  begin errors++; $display("FAIL drain_start word %0d got %0b exp 1", j, bus.o_tx_start); end
            checks++; if (bus.o_tx_data !== 8'(j))  begin errors++; $display("FAIL drain_data got %0h exp %0h", bus.o_tx_data, j); end
        end
        checks++; if (bus.o_empty !== 1'b1) begin errors++; $display("FAIL drain_empty got %0b exp 1", bus.o_empty); end
    endtask

    task automatic test_order_wrap();
        int wr_idx = 0;
        int rx_idx = 0;
        int cyc    = 0;
        do_reset();
        while (rx_idx < 40 && cyc < 3000) begin
            if (bus.o_tx_start === 1'b1) begin
                checks++; if (bus.o_tx_data !== 8'(rx_idx)) begin errors++; $display("FAIL order_data got %0h exp %0h", bus.o_tx_data, rx_idx); end
                rx_idx++;
            end
            if (bus.o_overflow === 1'b1) begin
                errors++; $display("FAIL order_overflow got 1 exp 0 at cycle %0d", cyc);
            end
            bus.i_wr           = (wr_idx < 40) && !bus.o_full;
            bus.i_wr_data      = 8'(wr_idx);
            if (bus.i_wr) wr_idx++;
            bus.i_tx_done_tick = (cyc % 20) == 19;
            cyc++;
            @(negedge i_clock);
        end
        bus.i_wr           = 1'b0;
        bus.i_tx_done_tick = 1'b0;
        checks++; if (rx_idx != 40) begin errors++; $display("FAIL order_timeout got %0d starts exp 40", rx_idx); end
        checks++; if (bus.o_count !== 5'd0) begin errors++; $display("FAIL order_final_count got %0d exp 0", bus.o_count); end
    endtask

    task automatic test_simultaneous();
        do_reset();
        for (int k = 0; k < 4; k++) begin
            bus.i_wr      = 1'b1;
            bus.i_wr_data = 8'h50 + 8'(k);
            @(negedge i_clock);
        end
        bus.i_wr = 1'b0;
        checks++; if (bus.o_count !== 5'd3) begin errors++; $display("FAIL simul_pre_count got %0d exp 3", bus.o_count); end
        bus.i_tx_done_tick = 1'b1;
        @(negedge i_clock);
        bus.i_tx_done_tick = 1'b0;
        checks++; if (bus.o_count !== 5'd3) begin errors++; $display("FAIL simul_after_tick_count got %0d exp 3", bus.o_count); end
        bus.i_wr      = 1'b1;
        bus.i_wr_data = 8'h54;
        @(negedge i_clock);
        bus.i_wr = 1'b0;
        checks++; if (bus.o_count !== 5'd3)    begin errors++; $display("FAIL simul_count got %0d exp 3", bus.o_count); end
        checks++; if (bus.o_tx_start !== 1'b1) begin errors++; $display("FAIL simul_start got %0b exp 1", bus.o_tx_start); end
        checks++; if (bus.o_tx_data !== 8'h51) begin errors++; $display("FAIL simul_data got %0h exp 51", bus.o_tx_data); end
        for (int j = 2; j <= 4; j++) begin
            bus.i_tx_done_tick = 1'b1;
            @(negedge i_clock);
            bus.i_tx_done_tick = 1'b0;
            @(negedge i_clock);
            checks++; if (bus.o_tx_data !== 8'h50 + 8'(j)) begin errors++; $display("FAIL simul_order got %0h exp %0h", bus.o_tx_data, 8'h50 + 8'(j)); end
        end
    endtask

    task automatic test_reset_mid();
        do_reset();
        for (int k = 0; k < 6; k++) begin
            bus.i_wr      = 1'b1;
            bus.i_wr_data = 8'h60 + 8'(k);
            @(negedge i_clock);
        end
        bus.i_wr = 1'b0;
        checks++; if (bus.o_count !== 5'd5)    begin errors++; $display("FAIL mid_pre_count got %0d exp 5", bus.o_count); end
        checks++; if (bus.o_tx_data !== 8'h60) begin errors++; $display("FAIL mid_pre_data got %0h exp 60", bus.o_tx_data); end
        #2 i_reset = 1'b0;
        #1;
        checks++; if (bus.o_count !== 5'd0)    begin errors++; $display("FAIL mid_count got %0d exp 0", bus.o_count); end
        checks++; if (bus.o_empty !== 1'b1)    begin errors++; $display("FAIL mid_empty got %0b exp 1", bus.o_empty); end
        checks++; if (bus.o_full !== 1'b0)     begin errors++; $display("FAIL mid_full got %0b exp 0", bus.o_full); end
        checks++; if (bus.o_tx_start !== 1'b0) begin errors++; $display("FAIL mid_start got %0b exp 0", bus.o_tx_start); end
        checks++; if (bus.o_tx_data !== 8'h00) begin errors++; $display("FAIL mid_data got %0h exp 00", bus.o_tx_data); end
        checks++; if (bus.o_overflow !== 1'b0) begin errors++; $display("FAIL mid_overflow got %0b exp 0", bus.o_overflow); end
        @(negedge i_clock);
        i_reset = 1'b1;
        @(negedge i_clock);
        checks++; if (bus.o_tx_start !== 1'b0) begin errors++; $display("FAIL mid_release_start got %0b exp 0", bus.o_tx_start); end
        bus.i_wr      = 1'b1;
        bus.i_wr_data = 8'h3C;
        @(negedge i_clock);
        bus.i_wr = 1'b0;
        @(negedge i_clock);
        checks++; if (bus.o_tx_start !== 1'b1) begin errors++; $display("FAIL mid_new_start got %0b exp 1", bus.o_tx_start); end
        checks++; if (bus.o_tx_data !== 8'h3C) begin errors++; $display("FAIL mid_new_data got %0h exp 3c", bus.o_tx_data); end
    endtask

    initial begin
        bus.i_wr           = 1'b0;
        bus.i_wr_data      = 8'h00;
        bus.i_tx_done_tick = 1'b0;
        test_reset();
        test_single_byte();
        test_fill_overflow();
        test_order_wrap();
        test_simultaneous();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/uart_tx_fifo.md
# uart_tx_fifo

Transmit buffer and sequencer sitting directly upstream of the UART transmitter. Accepts bytes from the application side into a circular FIFO and hands them to the transmitter one at a time: one-cycle start pulse with stable data, then waits for the transmitter's done tick before issuing the next byte. Decouples bursty producers from the baud-rate-limited serial line.

## Interface

- NB_DATA, 8, data word width; matches transmitter data width
- NB_ADDR, 4, FIFO address width; depth = 2**NB_ADDR (16)

- i_clock  input  1  system clock, all logic on rising edge
- i_reset  input  1  asynchronous, active-low reset (0 = reset)
- i_wr  input  1  write strobe; one word accepted per cycle while high
- i_wr_data  input  NB_DATA  word to enqueue, sampled with i_wr
- o_full  output  1  FIFO holds 2**NB_ADDR words
- o_empty  output  1  FIFO holds 0 words
- o_count  output  NB_ADDR+1  current occupancy, 0..2**NB_ADDR
- o_overflow  output  1  one-cycle pulse: write attempted while full, word dropped
- i_tx_done_tick  input  1  one-cycle tick from transmitter, frame finished
- o_tx_start  output  1  one-cycle pulse to transmitter, start frame
- o_tx_data  output  NB_DATA  word for transmitter; registered, stable from o_tx_start until next pop

## Operation

- Storage: 2**NB_ADDR x NB_DATA register array, write pointer, read pointer (NB_ADDR bits, wrap modulo depth), occupancy counter (NB_ADDR+1 bits).
- o_full = (count == 2**NB_ADDR); o_empty = (count == 0); both combinational from count register.
- Write: if i_wr and not o_full, store at wr_ptr, wr_ptr+1. If i_wr and o_full, drop word, pulse o_overflow next cycle. Full is judged on pre-edge count; a write while full is dropped even if a pop occurs at the same edge.
- Pop: performed by FSM only; reads mem[rd_ptr] into o_tx_data, rd_ptr+1.
- Count: +1 on accepted write only, -1 on pop only, unchanged on both or neither.
- FSM states:
  - IDLE: if not o_empty -> pop, set o_tx_start, go WAIT. Else stay. i_tx_done_tick ignored.
  - WAIT: o_tx_start cleared after one cycle; stay until i_tx_done_tick, then go IDLE.
- Only one frame outstanding at any time; no pop while in WAIT.

## Timing

- Reset (i_reset = 0, asynchronous): state IDLE, pointers 0, count 0, o_empty 1, o_full 0, o_count 0, o_overflow 0, o_tx_start 0, o_tx_data 0. Memory contents not reset.
- Reset mid-frame: everything returns to reset values immediately; queued words are lost; transmitter shares the reset.
- Write-to-start latency, FIFO empty and IDLE: i_wr sampled at edge E0 -> o_empty low after E0 -> pop at E1 -> o_tx_start high for exactly the cycle E1..E2, o_tx_data valid from E1.
- Done-to-next-start: i_tx_done_tick sampled at edge Ed -> IDLE after Ed -> next pop at Ed+1 -> o_tx_start high Ed+1..Ed+2.
- Write into empty FIFO at the same edge as a done tick: word counted, popped at the following edge per the rule above.
- Pointer wrap: after address 2**NB_ADDR-1 next address is 0; no gap or duplicate.
- o_overflow: registered, high exactly one cycle per dropped write; consecutive dropped writes give consecutive high cycles.

## Test plan

- Reset: hold i_reset=0 with random inputs -> o_empty=1, o_full=0, o_count=0, o_tx_start=0, o_tx_data=0; release, no start pulse while empty.
- Single byte: write 0xA5 into empty FIFO at E0 -> o_tx_start high only during E1..E2, o_tx_data=0xA5; no second start until i_tx_done_tick; after tick o_count=0.
- Fill and overflow: with done tick held off, write 0x00..0x10 (17 words) back-to-back -> first popped to transmitter, o_count reaches 16, o_full=1; 18th write gives one-cycle o_overflow, count stays 16.
- Order and wrap: stream 40 words 0x00..0x27 with done tick every 20 cycles -> o_tx_data sequence exactly 0x00..0x27, one o_tx_start per word, pointers wrap twice without loss.
- Simultaneous write and pop: count=3 in IDLE after done tick, assert i_wr at the pop edge -> count stays 3, written word appears after the earlier three.
- Reset mid-operation: assert i_reset=0 during WAIT with count=5 -> all outputs to reset values immediately; after release, new write 0x3C is the first word sent.
